// File: rtl/ram_pattern_checker_if.sv
`default_nettype none
//==============================================================================
// Module  : ram_pattern_checker_if
// Brief   : RAM-side bus between the pattern checker (master) and the RAM.
// Revision: 1.0
//==============================================================================
interface ram_pattern_checker_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wren;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;

    modport master (
        output ram_addr,
        output ram_wren,
        output ram_wdata,
        input  ram_rdata
    );

    modport slave (
        input  ram_addr,
        input  ram_wren,
        input  ram_wdata,
        output ram_rdata
    );
endinterface

`default_nettype wire

// File: rtl/ram_pattern_checker.sv
`default_nettype none
//==============================================================================
// Module  : ram_pattern_checker
// Brief   : Write/read-back pattern self-test engine for a synchronous RAM.
//           Define RAM_MARCH_INVERSE_EN to add a descending inverted pass.
// Revision: 1.0
//==============================================================================
module ram_pattern_checker #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 10,
    parameter int DEPTH     = 1024,
    parameter int READ_LAT  = 1,
    parameter int ERR_CNT_W = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    input  wire logic                 start,
    input  wire logic [2:0]           mode,
    ram_pattern_checker_if.master     ram,
    output logic                      busy,
    output logic                      done,
    output logic                      pass,
    output logic [DATA_W-1:0]         err_bits,
    output logic [ERR_CNT_W-1:0]      err_count,
    output logic [ADDR_W-1:0]         first_err_addr,
    output logic                      first_err_valid
);
    localparam logic [ADDR_W-1:0] c_last_addr  = ADDR_W'(DEPTH - 1);
    localparam logic [1:0]        c_drain_last = 2'(READ_LAT - 1);

`ifdef RAM_MARCH_INVERSE_EN
    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE, S_WRITE_INV, S_READ_INV
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE
    } state_t;
`endif

    state_t              r_state;
    state_t              w_state_nxt;
    logic [2:0]          r_mode;
    logic [ADDR_W-1:0]   r_addr;
    logic [1:0]          r_drain_cnt;
    logic                w_write;
    logic                w_issue;
    logic                w_invert;
    logic                w_addr_last;
    logic [DATA_W-1:0]   w_pattern;
    logic [DATA_W-1:0]   w_expect;
    logic [DATA_W-1:0]   w_diff;
    logic                w_mismatch;
    logic [READ_LAT-1:0] r_pv;
    logic [ADDR_W-1:0]   r_pa [READ_LAT];
    logic [DATA_W-1:0]   r_pe [READ_LAT];
`ifdef RAM_MARCH_INVERSE_EN
    logic                r_inv_phase;
    logic                w_addr_first;
`endif

    function automatic logic [DATA_W-1:0] f_pattern(input logic [2:0]        m,
                                                    input logic [ADDR_W-1:0] a);
        logic [DATA_W+ADDR_W-1:0] v_ext;
        logic [DATA_W-1:0]        v_chk;
        v_ext = {{DATA_W{1'b0}}, a};
        // Even bit positions set on even addresses (0x55..), odd ones on odd (0xAA..).
        for (int i = 0; i < DATA_W; i++)
            v_chk[i] = ((i % 2) == 0) ? ~a[0] : a[0];
        case (m)
            3'd1:    f_pattern = {DATA_W{1'b1}};
            3'd2:    f_pattern = v_chk;
            3'd3:    f_pattern = v_ext[DATA_W-1:0];
            3'd4:    f_pattern = ~v_ext[DATA_W-1:0];
            default: f_pattern = '0;
        endcase
    endfunction

    assign w_addr_last = (r_addr == c_last_addr);
`ifdef RAM_MARCH_INVERSE_EN
    assign w_addr_first = (r_addr == '0);
`endif
    assign w_pattern = f_pattern(r_mode, r_addr);
    assign w_expect  = w_invert ? ~w_pattern : w_pattern;

    assign ram.ram_addr  = r_addr;
    assign ram.ram_wren  = w_write;
    assign ram.ram_wdata = w_write ? w_expect : '0;

    assign w_diff     = ram.ram_rdata ^ r_pe[READ_LAT-1];
    assign w_mismatch = r_pv[READ_LAT-1] && (w_diff != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_write     = 1'b0;
        w_issue     = 1'b0;
        w_invert    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_state_nxt = S_WRITE;
            S_WRITE: begin
                busy    = 1'b1;
                w_write = 1'b1;
                if (w_addr_last) w_state_nxt = S_READ;
            end
            S_READ: begin
                busy    = 1'b1;
                w_issue = 1'b1;
                if (w_addr_last) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (r_drain_cnt == c_drain_last) begin
`ifdef RAM_MARCH_INVERSE_EN
                    w_state_nxt = r_inv_phase ? S_DONE : S_WRITE_INV;
`else
                    w_state_nxt = S_DONE;
`endif
                end
            end
`ifdef RAM_MARCH_INVERSE_EN
            S_WRITE_INV: begin
                busy     = 1'b1;
                w_write  = 1'b1;
                w_invert = 1'b1;
                if (w_addr_first) w_state_nxt = S_READ_INV;
            end
            S_READ_INV: begin
                busy     = 1'b1;
                w_issue  = 1'b1;
                w_invert = 1'b1;
                if (w_addr_first) w_state_nxt = S_DRAIN;
            end
`endif
            S_DONE: begin
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mode      <= '0;
            r_addr      <= '0;
            r_drain_cnt <= '0;
`ifdef RAM_MARCH_INVERSE_EN
            r_inv_phase <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_addr <= '0;
                    if (start) r_mode <= mode;
                end
                S_WRITE: r_addr <= w_addr_last ? '0 : r_addr + 1'b1;
                S_READ:  if (!w_addr_last) r_addr <= r_addr + 1'b1;
`ifdef RAM_MARCH_INVERSE_EN
                S_WRITE_INV: r_addr <= w_addr_first ? c_last_addr : r_addr - 1'b1;
                S_READ_INV:  if (!w_addr_first) r_addr <= r_addr - 1'b1;
`endif
                S_DONE:  r_addr <= '0;
                default: ;
            endcase
            r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + 2'd1 : 2'd0;
`ifdef RAM_MARCH_INVERSE_EN
            if (r_state == S_IDLE)
                r_inv_phase <= 1'b0;
            else if (r_state == S_DRAIN && w_state_nxt == S_WRITE_INV)
                r_inv_phase <= 1'b1;
`endif
        end
    end

    // Address and expected word travel alongside the RAM's read latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pv <= '0;
            for (int i = 0; i < READ_LAT; i++) begin
                r_pa[i] <= '0;
                r_pe[i] <= '0;
            end
        end else begin
            r_pv[0] <= w_issue;
            r_pa[0] <= r_addr;
            r_pe[0] <= w_expect;
            for (int i = 1; i < READ_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pa[i] <= r_pa[i-1];
                r_pe[i] <= r_pe[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass            <= 1'b0;
            err_bits        <= '0;
            err_count       <= '0;
            first_err_addr  <= '0;
            first_err_valid <= 1'b0;
        end else if (r_state == S_IDLE && start) begin
            pass            <= 1'b0;
            err_bits        <= '0;
            err_count       <= '0;
            first_err_addr  <= '0;
            first_err_valid <= 1'b0;
        end else begin
            if (w_mismatch) begin
                err_bits <= err_bits | w_diff;
                if (err_count != {ERR_CNT_W{1'b1}})
                    err_count <= err_count + 1'b1;
                if (!first_err_valid) begin
                    first_err_valid <= 1'b1;
                    first_err_addr  <= r_pa[READ_LAT-1];
                end
            end
            // The last compare lands on the same edge that enters DONE.
            if (r_state == S_DRAIN && w_state_nxt == S_DONE)
                pass <= !(first_err_valid || w_mismatch);
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_ram_pattern_checker.sv
`timescale 1ns/1ps
`default_nettype none
//==============================================================================
// Module  : tb_ram_pattern_checker
// Brief   : Scoreboard bench with a fault-injecting RAM model for the checker.
// Revision: 1.0
//==============================================================================
module tb_ram_pattern_checker;
    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 5;
    localparam int DEPTH     = 16;
    localparam int READ_LAT  = 3;
    localparam int ERR_CNT_W = 3;
    localparam int CNT_MAX   = (1 << ERR_CNT_W) - 1;
    localparam int NWORDS    = 1 << ADDR_W;
`ifdef RAM_MARCH_INVERSE_EN
    localparam int NPASS     = 2;
    localparam int LATENCY   = 4*DEPTH + 2*READ_LAT + 1;
`else
    localparam int NPASS     = 1;
    localparam int LATENCY   = 2*DEPTH + READ_LAT + 1;
`endif

    typedef struct {
        int                start_cyc;
        logic [DATA_W-1:0] bits;
        int                cnt;
        int                faddr;
        bit                fvalid;
        bit                ok;
    } exp_t;

    typedef struct {
        int                addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic [2:0] mode = 3'd0;
    logic busy, done, pass, first_err_valid;
    logic [DATA_W-1:0]    err_bits;
    logic [ERR_CNT_W-1:0] err_count;
    logic [ADDR_W-1:0]    first_err_addr;

    int cyc   = 0;
    int n_chk = 0;
    int n_err = 0;
    exp_t expq[$];
    wr_t  wq[$];

    logic [DATA_W-1:0] mem   [NWORDS];
    logic [DATA_W-1:0] s1    [NWORDS];
    logic [DATA_W-1:0] s0    [NWORDS];
    logic [DATA_W-1:0] rpipe [READ_LAT];
    bit al_en   = 1'b0;
    int al_from = 0;
    int al_to   = 0;

    ram_pattern_checker_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) rif ();

    ram_pattern_checker #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH),
        .READ_LAT(READ_LAT), .ERR_CNT_W(ERR_CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .ram(rif),
        .busy(busy), .done(done), .pass(pass), .err_bits(err_bits),
        .err_count(err_count), .first_err_addr(first_err_addr),
        .first_err_valid(first_err_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int phys(input int a);
        return (al_en && a == al_from) ? al_to : a;
    endfunction

    function automatic logic [DATA_W-1:0] fault_rd(input int a);
        return (mem[phys(a)] | s1[a]) & ~s0[a];
    endfunction

    // RAM under test: aliasing on both ports, stuck-at bits on the read port.
    always @(posedge clk) begin
        if (rif.ram_wren) mem[phys(int'(rif.ram_addr))] <= rif.ram_wdata;
        rpipe[0] <= fault_rd(int'(rif.ram_addr));
        for (int i = 1; i < READ_LAT; i++) rpipe[i] <= rpipe[i-1];
    end
    assign rif.ram_rdata = rpipe[READ_LAT-1];

    function automatic logic [DATA_W-1:0] ref_pattern(input int m, input int a);
        logic [63:0] five;
        logic [63:0] av;
        five = 64'h5555_5555_5555_5555;
        av   = 64'(a);
        case (m)
            1:       return '1;
            2:       return (a % 2 == 0) ? five[DATA_W-1:0] : ~five[DATA_W-1:0];
            3:       return av[DATA_W-1:0];
            4:       return ~av[DATA_W-1:0];
            default: return '0;
        endcase
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: replay the whole march on a plain array and tally the outcome.
    task automatic build_expect(input int m);
        logic [DATA_W-1:0] mm [NWORDS];
        logic [DATA_W-1:0] p, rd, diff;
        exp_t e;
        wr_t  w;
        int   a, nerr;
        for (int i = 0; i < NWORDS; i++) mm[i] = '0;
        e.start_cyc = cyc; e.bits = '0; e.fvalid = 1'b0; e.faddr = 0;
        nerr = 0;
        for (int ph = 0; ph < NPASS; ph++) begin
            for (int k = 0; k < DEPTH; k++) begin
                a = (ph == 0) ? k : DEPTH - 1 - k;
                p = ref_pattern(m, a);
                if (ph == 1) p = ~p;
                w.addr = a; w.data = p;
                wq.push_back(w);
                mm[phys(a)] = p;
            end
            for (int k = 0; k < DEPTH; k++) begin
                a = (ph == 0) ? k : DEPTH - 1 - k;
                p = ref_pattern(m, a);
                if (ph == 1) p = ~p;
                rd   = (mm[phys(a)] | s1[a]) & ~s0[a];
                diff = rd ^ p;
                if (diff != '0) begin
                    e.bits |= diff;
                    nerr++;
                    if (!e.fvalid) begin e.fvalid = 1'b1; e.faddr = a; end
                end
            end
        end
        e.cnt = (nerr > CNT_MAX) ? CNT_MAX : nerr;
        e.ok  = (nerr == 0);
        expq.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        wr_t  w;
        if (rif.ram_wren) begin
            if (wq.size() == 0) check("unexpected_write", 1, 0);
            else begin
                w = wq.pop_front();
                check("wr_addr", rif.ram_addr, w.addr);
                check("wr_data", rif.ram_wdata, w.data);
            end
        end else begin
            check("wdata_idle", rif.ram_wdata, 0);
        end
        if (done) begin
            if (expq.size() == 0) check("unexpected_done", 1, 0);
            else begin
                e = expq.pop_front();
                check("latency", cyc - e.start_cyc, LATENCY);
                check("busy_at_done", busy, 0);
                check("pass", pass, e.ok);
                check("err_count", err_count, e.cnt);
                check("err_bits", err_bits, e.bits);
                check("first_err_valid", first_err_valid, e.fvalid);
                if (e.fvalid) check("first_err_addr", first_err_addr, e.faddr);
            end
        end
    end

    task automatic clear_faults();
        for (int i = 0; i < NWORDS; i++) begin s1[i] = '0; s0[i] = '0; end
        al_en = 1'b0;
    endtask

    task automatic issue_start(input int m);
        build_expect(m);
        start = 1'b1;
        mode  = 3'(m);
        @(negedge clk);
        start = 1'b0;
        mode  = 3'($urandom_range(0, 7));
        check("busy_after_start", busy, 1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < LATENCY + 20; i++) begin
            if (done) break;
            @(negedge clk);
        end
        if (!done) check("done_timeout", 0, 1);
    endtask

    task automatic run_test(input int m);
        issue_start(m);
        wait_done();
        repeat (2) @(negedge clk);
    endtask

    task automatic reset_check(input string tag);
        rst_n = 1'b0;
        #1;
        check({tag, "_wren"}, rif.ram_wren, 0);
        check({tag, "_addr"}, rif.ram_addr, 0);
        check({tag, "_wdata"}, rif.ram_wdata, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_pass"}, pass, 0);
        check({tag, "_err_bits"}, err_bits, 0);
        check({tag, "_err_count"}, err_count, 0);
        check({tag, "_first_addr"}, first_err_addr, 0);
        check({tag, "_first_valid"}, first_err_valid, 0);
        expq.delete();
        wq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clear_faults();
        for (int i = 0; i < NWORDS; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        reset_check("reset_init");

        run_test(2);                                   // clean checkerboard

        s1[5] = 8'h08;                                 // bit 3 stuck-at-1 at address 5
        run_test(0);
        clear_faults();

        for (int i = 0; i < NWORDS; i++) s0[i] = 8'h10; // bit 4 stuck-at-0 everywhere
        run_test(1);
        clear_faults();
        reset_check("reset_idle");

        issue_start(2);                                // abort mid-write at address 7
        for (int i = 0; i < 20; i++) begin
            if (rif.ram_wren && rif.ram_addr == 5'd7) break;
            @(negedge clk);
        end
        check("reached_addr7", rif.ram_addr, 7);
        reset_check("reset_mid");
        run_test(4);

        issue_start(3);                                // starts during busy and done are ignored
        repeat (5) @(negedge clk);
        start = 1'b1; mode = 3'd1;
        @(negedge clk);
        start = 1'b0;
        wait_done();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (LATENCY + 10) @(negedge clk);
        check("idle_after_ignored", busy, 0);

        al_en = 1'b1; al_from = 9; al_to = 6;          // decoder aliases 9 onto 6
        run_test(4);
        clear_faults();

        for (int t = 0; t < 10; t++) begin
            clear_faults();
            case ($urandom_range(0, 3))
                1: s1[$urandom_range(0, DEPTH-1)] = DATA_W'(1) << $urandom_range(0, DATA_W-1);
                2: begin
                    logic [DATA_W-1:0] b;
                    b = DATA_W'(1) << $urandom_range(0, DATA_W-1);
                    for (int i = 0; i < NWORDS; i++) s0[i] = b;
                end
                3: begin
                    al_en   = 1'b1;
                    al_from = int'($urandom_range(0, DEPTH-1));
                    al_to   = (al_from + int'($urandom_range(1, DEPTH-1))) % DEPTH;
                end
                default: ;
            endcase
            run_test(int'($urandom_range(0, 7)));
        end

        repeat (5) @(negedge clk);
        check("expq_empty", expq.size(), 0);
        check("wq_empty", wq.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

`default_nettype wire
